// File: rtl/segmentation_translate_pipeline_if.sv
// ---------------------------------------------------------------------------
// segmentation_translate_pipeline_if
//
// Request/response bus of the segmentation translate pipeline.
//   Request  (upstream -> pipeline): i_req_valid, o_req_ready, i_req_index,
//            i_req_offset, i_req_size, i_req_write, i_req_fetch
//   Response (pipeline -> downstream): o_rsp_valid, i_rsp_ready,
//            o_rsp_linear_address, o_rsp_fault, o_rsp_fault_code
// Signal names carry the pipeline's point of view (i_ = into the pipeline).
// modport slave  : the translate pipeline itself
// modport master : whoever drives requests and consumes responses
// ---------------------------------------------------------------------------
interface segmentation_translate_pipeline_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_WIDTH   = 3
);
    logic                     i_req_valid;
    logic                     o_req_ready;
    logic [INDEX_WIDTH-1:0]   i_req_index;
    logic [ADDRESS_WIDTH-1:0] i_req_offset;
    logic [1:0]               i_req_size;
    logic                     i_req_write;
    logic                     i_req_fetch;

    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic [ADDRESS_WIDTH-1:0] o_rsp_linear_address;
    logic                     o_rsp_fault;
    logic [2:0]               o_rsp_fault_code;

    modport slave (
        input  i_req_valid, i_req_index, i_req_offset, i_req_size,
               i_req_write, i_req_fetch, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_linear_address,
               o_rsp_fault, o_rsp_fault_code
    );

    modport master (
        output i_req_valid, i_req_index, i_req_offset, i_req_size,
               i_req_write, i_req_fetch, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_linear_address,
               o_rsp_fault, o_rsp_fault_code
    );
endinterface

// File: rtl/segmentation_translate_pipeline.sv
// ---------------------------------------------------------------------------
// segmentation_translate_pipeline
//
// Two-stage translation of (segment index, offset) into a linear address
// with a prioritised fault code, backed by a shadow cache of selectors and
// raw 386 descriptors for SEGMENT_COUNT segment registers (index 0 = CS).
//
// Ports:
//   clock, reset                  clock; asynchronous active-low reset
//   i_protected_mode              CR0.PE, sampled when a request is accepted
//   i_current_privilege_level     CPL, sampled when a request is accepted
//   i_load_*                      shadow entry write (selector + descriptor)
//   bus (slave)                   request / response handshake bus
//   o_accessed_set_valid/_index   accessed-bit writeback pulse (optional)
//
// Optional feature macro: SEGMENTATION_ACCESSED_WRITEBACK_EN
//   When defined, a clean protected-mode response whose descriptor has the
//   accessed bit clear sets that bit in the shadow and pulses the
//   o_accessed_set_* ports for one cycle.
//
// Fault codes: 0 none, 1 null selector, 2 not present, 3 privilege,
//              4 type, 5 limit.
// ---------------------------------------------------------------------------
module segmentation_translate_pipeline #(
    parameter int SEGMENT_COUNT = 6,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_WIDTH   = $clog2(SEGMENT_COUNT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_protected_mode,
    input  logic [1:0]             i_current_privilege_level,
    input  logic                   i_load_valid,
    input  logic [INDEX_WIDTH-1:0] i_load_index,
    input  logic [15:0]            i_load_selector,
    input  logic [63:0]            i_load_descriptor,
    segmentation_translate_pipeline_if.slave bus
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
    ,
    output logic                   o_accessed_set_valid,
    output logic [INDEX_WIDTH-1:0] o_accessed_set_index
`endif
);

    localparam logic [INDEX_WIDTH:0] SEG_COUNT_W = (INDEX_WIDTH + 1)'(SEGMENT_COUNT);
    localparam logic [32:0]          ADDR_MAX    = (33'd1 << ADDRESS_WIDTH) - 33'd1;

    // ---------------------------------------------------------------------
    // Shadow cache
    // ---------------------------------------------------------------------
    logic [15:0] sel_q  [SEGMENT_COUNT];
    logic [63:0] desc_q [SEGMENT_COUNT];

    logic load_in_range;
    assign load_in_range = ({1'b0, i_load_index} < SEG_COUNT_W);

    // ---------------------------------------------------------------------
    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. A stage holds its contents (and o_rsp_* stays stable) while
    // its valid is high and the consumer is not ready. Each stage refills
    // when it is empty or its content leaves on the same edge.
    // ---------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_advance;
    logic req_ready;
    logic req_accept;

    assign s2_advance = ~s2_valid_q | bus.i_rsp_ready;
    assign req_ready  = ~s1_valid_q | s2_advance;
    assign req_accept = bus.i_req_valid & req_ready;

    // ---------------------------------------------------------------------
    // Accept-side lookup and decode (shadow as it was before this edge)
    // ---------------------------------------------------------------------
    logic [15:0] req_sel;
    logic [63:0] req_desc;
    logic [1:0]  size_m1;
    logic [32:0] end_d;
    logic [31:0] base_d;
    logic [19:0] limit_d;
    logic        unused_desc_bits;

    always_comb begin
        req_sel  = '0;
        req_desc = '0;
        if ({1'b0, bus.i_req_index} < SEG_COUNT_W) begin
            req_sel  = sel_q[bus.i_req_index];
            req_desc = desc_q[bus.i_req_index];
        end
    end

    // Reserved size 3 behaves like a 4-byte access.
    always_comb begin
        case (bus.i_req_size)
            2'd0:    size_m1 = 2'd0;
            2'd1:    size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
    end

    assign end_d   = 33'(bus.i_req_offset) + {31'd0, size_m1};
    assign base_d  = {req_desc[63:56], req_desc[39:16]};
    assign limit_d = {req_desc[51:48], req_desc[15:0]};
    // AVL/L bits and the accessed bit play no part in the checks.
    assign unused_desc_bits = ^{req_desc[53:52], req_desc[40]};

    // ---------------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------------
    logic                     s1_pm_q;
    logic [1:0]               s1_cpl_q;
    logic [INDEX_WIDTH-1:0]   s1_index_q;
    logic [ADDRESS_WIDTH-1:0] s1_offset_q;
    logic [32:0]              s1_end_q;
    logic                     s1_write_q;
    logic                     s1_fetch_q;
    logic [15:0]              s1_sel_q;
    logic [31:0]              s1_base_q;
    logic [19:0]              s1_limit_q;
    logic                     s1_g_q;
    logic                     s1_b_q;
    logic                     s1_p_q;
    logic [1:0]               s1_dpl_q;
    logic                     s1_s_q;
    logic [3:1]               s1_type_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_pm_q     <= 1'b0;
            s1_cpl_q    <= '0;
            s1_index_q  <= '0;
            s1_offset_q <= '0;
            s1_end_q    <= '0;
            s1_write_q  <= 1'b0;
            s1_fetch_q  <= 1'b0;
            s1_sel_q    <= '0;
            s1_base_q   <= '0;
            s1_limit_q  <= '0;
            s1_g_q      <= 1'b0;
            s1_b_q      <= 1'b0;
            s1_p_q      <= 1'b0;
            s1_dpl_q    <= '0;
            s1_s_q      <= 1'b0;
            s1_type_q   <= '0;
        end else begin
            if (req_ready) begin
                s1_valid_q <= bus.i_req_valid;
            end
            if (req_accept) begin
                s1_pm_q     <= i_protected_mode;
                s1_cpl_q    <= i_current_privilege_level;
                s1_index_q  <= bus.i_req_index;
                s1_offset_q <= bus.i_req_offset;
                s1_end_q    <= end_d;
                s1_write_q  <= bus.i_req_write;
                s1_fetch_q  <= bus.i_req_fetch;
                s1_sel_q    <= req_sel;
                s1_base_q   <= base_d;
                s1_limit_q  <= limit_d;
                s1_g_q      <= req_desc[55];
                s1_b_q      <= req_desc[54];
                s1_p_q      <= req_desc[47];
                s1_dpl_q    <= req_desc[46:45];
                s1_s_q      <= req_desc[44];
                s1_type_q   <= req_desc[43:41];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Checks and address generation feeding stage 2
    // ---------------------------------------------------------------------
    logic [31:0]              eff_limit;
    logic [31:0]              off32;
    logic [31:0]              linear32;
    logic [1:0]               max_pl;
    logic                     is_code;
    logic                     expand_down;
    logic                     null_bad;
    logic                     present_bad;
    logic                     priv_bad;
    logic                     type_bad;
    logic                     limit_bad;
    logic [ADDRESS_WIDTH-1:0] linear_d;
    logic [2:0]               fault_code_d;

    always_comb begin
        off32       = 32'(s1_offset_q);
        eff_limit   = s1_g_q ? {s1_limit_q, 12'hFFF} : {12'h000, s1_limit_q};
        max_pl      = (s1_cpl_q > s1_sel_q[1:0]) ? s1_cpl_q : s1_sel_q[1:0];
        is_code     = s1_type_q[3];
        expand_down = ~is_code & s1_type_q[2];

        null_bad    = (s1_index_q != '0) && (s1_sel_q[15:2] == 14'd0);
        present_bad = ~s1_p_q | ~s1_s_q;
        // Conforming code (code with type[2]=1) and fetches skip the check.
        priv_bad    = ~s1_fetch_q & (~is_code | ~s1_type_q[2]) & (max_pl > s1_dpl_q);
        type_bad    = (s1_write_q & is_code)
                    | (s1_write_q & ~is_code & ~s1_type_q[1])
                    | (~s1_write_q & ~s1_fetch_q & is_code & ~s1_type_q[1])
                    | (s1_fetch_q & ~is_code)
                    | (s1_write_q & (s1_index_q == '0));

        if (expand_down) begin
            // Valid offsets lie strictly above the limit, up to 64K or 4G.
            limit_bad = (off32 <= eff_limit)
                      | (s1_end_q > (s1_b_q ? 33'h0_FFFF_FFFF : 33'h0_0000_FFFF));
        end else begin
            limit_bad = (s1_end_q > {1'b0, eff_limit}) | (s1_end_q > ADDR_MAX);
        end

        fault_code_d = 3'd0;
        if (s1_pm_q) begin
            if (null_bad)         fault_code_d = 3'd1;
            else if (present_bad) fault_code_d = 3'd2;
            else if (priv_bad)    fault_code_d = 3'd3;
            else if (type_bad)    fault_code_d = 3'd4;
            else if (limit_bad)   fault_code_d = 3'd5;
        end

        linear32 = s1_pm_q ? (s1_base_q + off32) : ({12'h000, s1_sel_q, 4'h0} + off32);
        linear_d = linear32[ADDRESS_WIDTH-1:0];
    end

    // ---------------------------------------------------------------------
    // Stage 2 registers
    // ---------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] s2_linear_q;
    logic [2:0]               s2_code_q;
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
    logic [INDEX_WIDTH-1:0]   s2_index_q;
    logic                     s2_pm_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid_q  <= 1'b0;
            s2_linear_q <= '0;
            s2_code_q   <= '0;
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
            s2_index_q  <= '0;
            s2_pm_q     <= 1'b0;
`endif
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_linear_q <= linear_d;
                s2_code_q   <= fault_code_d;
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
                s2_index_q  <= s1_index_q;
                s2_pm_q     <= s1_pm_q;
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Accessed-bit writeback
    // ---------------------------------------------------------------------
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
    logic                   wb_fire;
    logic                   wb_valid_q;
    logic [INDEX_WIDTH-1:0] wb_index_q;

    // A same-edge shadow load to the same entry takes precedence.
    assign wb_fire = s2_valid_q & bus.i_rsp_ready & s2_pm_q & (s2_code_q == 3'd0)
                   & ({1'b0, s2_index_q} < SEG_COUNT_W)
                   & ~desc_q[s2_index_q][40]
                   & ~(i_load_valid & (i_load_index == s2_index_q));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            wb_index_q <= '0;
        end else begin
            wb_valid_q <= wb_fire;
            if (wb_fire) begin
                wb_index_q <= s2_index_q;
            end
        end
    end

    assign o_accessed_set_valid = wb_valid_q;
    assign o_accessed_set_index = wb_index_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEGMENT_COUNT; i++) begin
                sel_q[i]  <= '0;
                desc_q[i] <= '0;
            end
        end else begin
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
            if (wb_fire) begin
                desc_q[s2_index_q][40] <= 1'b1;
            end
`endif
            if (i_load_valid && load_in_range) begin
                sel_q[i_load_index]  <= i_load_selector;
                desc_q[i_load_index] <= i_load_descriptor;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.o_req_ready          = req_ready;
    assign bus.o_rsp_valid          = s2_valid_q;
    assign bus.o_rsp_linear_address = s2_linear_q;
    assign bus.o_rsp_fault_code     = s2_code_q;
    assign bus.o_rsp_fault          = (s2_code_q != 3'd0);

endmodule

// File: tb/tb_segmentation_translate_pipeline.sv
module tb_segmentation_translate_pipeline;

    logic        clock;
    logic        reset;
    logic        i_protected_mode;
    logic [1:0]  i_current_privilege_level;
    logic        i_load_valid;
    logic [2:0]  i_load_index;
    logic [15:0] i_load_selector;
    logic [63:0] i_load_descriptor;
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
    logic        accessed_valid;
    logic [2:0]  accessed_index;
    int          pulse_cnt = 0;
    logic [2:0]  last_pulse_idx = '0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    segmentation_translate_pipeline_if #(.ADDRESS_WIDTH(32), .INDEX_WIDTH(3)) bus ();

    segmentation_translate_pipeline #(
        .SEGMENT_COUNT(6),
        .ADDRESS_WIDTH(32)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .i_protected_mode          (i_protected_mode),
        .i_current_privilege_level (i_current_privilege_level),
        .i_load_valid              (i_load_valid),
        .i_load_index              (i_load_index),
        .i_load_selector           (i_load_selector),
        .i_load_descriptor         (i_load_descriptor),
        .bus                       (bus)
`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
        ,
        .o_accessed_set_valid      (accessed_valid),
        .o_accessed_set_index      (accessed_index)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
    always @(negedge clock) begin
        if (accessed_valid) begin
            pulse_cnt++;
            last_pulse_idx = accessed_index;
        end
    end
`endif

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- helpers / drivers ----------------
    function automatic logic [63:0] make_desc(input logic [31:0] base, input logic [19:0] limit,
                                              input logic g, input logic b, input logic p,
                                              input logic [1:0] dpl, input logic s,
                                              input logic [3:0] typ);
        logic [63:0] d;
        d = '0;
        d[63:56] = base[31:24];
        d[39:16] = base[23:0];
        d[51:48] = limit[19:16];
        d[15:0]  = limit[15:0];
        d[55]    = g;
        d[54]    = b;
        d[47]    = p;
        d[46:45] = dpl;
        d[44]    = s;
        d[43:40] = typ;
        return d;
    endfunction

    task automatic load_entry(input logic [2:0] idx, input logic [15:0] sel, input logic [63:0] desc);
        @(negedge clock);
        i_load_valid      = 1'b1;
        i_load_index      = idx;
        i_load_selector   = sel;
        i_load_descriptor = desc;
        @(negedge clock);
        i_load_valid      = 1'b0;
    endtask

    // One request into an empty pipeline; optionally a same-edge shadow load
    // of a new selector (descriptor 0) to the requested index.
    task automatic do_req(input string tag, input logic pm, input logic [1:0] cpl,
                          input logic [2:0] idx, input logic [31:0] off, input logic [1:0] sz,
                          input logic wr, input logic fe, input logic ld_en, input logic [15:0] ld_sel,
                          input logic [31:0] exp_lin, input logic [2:0] exp_code);
        int lat;
        @(negedge clock);
        i_protected_mode          = pm;
        i_current_privilege_level = cpl;
        bus.i_req_valid  = 1'b1;
        bus.i_req_index  = idx;
        bus.i_req_offset = off;
        bus.i_req_size   = sz;
        bus.i_req_write  = wr;
        bus.i_req_fetch  = fe;
        if (ld_en) begin
            i_load_valid      = 1'b1;
            i_load_index      = idx;
            i_load_selector   = ld_sel;
            i_load_descriptor = '0;
        end
        #1;
        check_eq({tag, "_rdy"}, 64'(bus.o_req_ready), 64'd1);
        @(negedge clock);
        bus.i_req_valid = 1'b0;
        i_load_valid    = 1'b0;
        lat = 1;
        while (!bus.o_rsp_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd2);
        check_eq({tag, "_lin"}, 64'(bus.o_rsp_linear_address), 64'(exp_lin));
        check_eq({tag, "_code"}, 64'(bus.o_rsp_fault_code), 64'(exp_code));
        check_eq({tag, "_flt"}, 64'(bus.o_rsp_fault), 64'(exp_code != 3'd0));
        @(posedge clock);
    endtask

    function automatic logic [31:0] stream_off(input int i);
        return 32'(i * 256 + i);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] d_rw3;
        int sent;
        int got;
        int cyc;
        bit saw_stall;
        logic [31:0] e;

        reset = 1'b0;
        i_protected_mode = 1'b0;
        i_current_privilege_level = 2'd0;
        i_load_valid = 1'b0;
        i_load_index = '0;
        i_load_selector = '0;
        i_load_descriptor = '0;
        bus.i_req_valid = 1'b0;
        bus.i_req_index = '0;
        bus.i_req_offset = '0;
        bus.i_req_size = '0;
        bus.i_req_write = 1'b0;
        bus.i_req_fetch = 1'b0;
        bus.i_rsp_ready = 1'b1;

        repeat (3) @(negedge clock);
        check_eq("rst_ready", 64'(bus.o_req_ready), 64'd1);
        check_eq("rst_valid", 64'(bus.o_rsp_valid), 64'd0);
        check_eq("rst_lin", 64'(bus.o_rsp_linear_address), 64'd0);
        check_eq("rst_code", 64'(bus.o_rsp_fault_code), 64'd0);
        reset = 1'b1;

        // Real mode
        load_entry(3'd1, 16'h1234, 64'd0);
        do_req("real", 1'b0, 2'd0, 3'd1, 32'h10, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0001_2350, 3'd0);
        load_entry(3'd1, 16'hFFFF, 64'd0);
        do_req("real_wrap", 1'b0, 2'd0, 3'd1, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h000F_FFEF, 3'd0);
        // Same-edge load: accept sees the old selector, the next request the new one
        do_req("ld_old", 1'b0, 2'd0, 3'd1, 32'h1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h2000, 32'h000F_FFF1, 3'd0);
        do_req("ld_new", 1'b0, 2'd0, 3'd1, 32'h1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0002_0001, 3'd0);

        // Protected, expand-up byte-granular data, DPL 3
        d_rw3 = make_desc(32'h0010_0000, 20'h00FFF, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0010);
        load_entry(3'd2, 16'h0013, d_rw3);
        do_req("pm_ok", 1'b1, 2'd3, 3'd2, 32'hFFC, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0010_0FFC, 3'd0);
        do_req("pm_lim", 1'b1, 2'd3, 3'd2, 32'hFFD, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0010_0FFD, 3'd5);

        // Page-granular limit
        load_entry(3'd3, 16'h001B, make_desc(32'h0000_2000, 20'h00001, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0010));
        do_req("g_ok", 1'b1, 2'd3, 3'd3, 32'h1FFF, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_3FFF, 3'd0);
        do_req("g_lim", 1'b1, 2'd3, 3'd3, 32'h2000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_4000, 3'd5);

        // Expand-down, B=0
        load_entry(3'd4, 16'h0023, make_desc(32'h0005_0000, 20'h00FFF, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0110));
        do_req("xd_low", 1'b1, 2'd3, 3'd4, 32'h0FFF, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0005_0FFF, 3'd5);
        do_req("xd_ok", 1'b1, 2'd3, 3'd4, 32'h1000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0005_1000, 3'd0);
        do_req("xd_high", 1'b1, 2'd3, 3'd4, 32'h1_0000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0006_0000, 3'd5);

        // Privilege: RPL 0, DPL 2
        load_entry(3'd5, 16'h0028, make_desc(32'h0, 20'hFFFFF, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0010));
        do_req("priv_bad", 1'b1, 2'd3, 3'd5, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_0010, 3'd3);
        do_req("priv_ok", 1'b1, 2'd2, 3'd5, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_0010, 3'd0);

        // CS: readable non-conforming code
        load_entry(3'd0, 16'h0008, make_desc(32'h1000, 20'hFFFFF, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1010));
        do_req("cs_write", 1'b1, 2'd0, 3'd0, 32'h100, 2'd2, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0000_1100, 3'd4);
        do_req("cs_fetch", 1'b1, 2'd0, 3'd0, 32'h100, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0000_1100, 3'd0);
        load_entry(3'd0, 16'h0008, make_desc(32'h1000, 20'hFFFFF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1010));
        do_req("np_fetch", 1'b1, 2'd0, 3'd0, 32'h20, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0000_1020, 3'd2);

        // Null selector on a non-CS index
        load_entry(3'd1, 16'h0003, make_desc(32'h0, 20'hFFFFF, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0010));
        do_req("null", 1'b1, 2'd3, 3'd1, 32'h40, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_0040, 3'd1);

        // Back-to-back stream with a 3-cycle response stall
        load_entry(3'd1, 16'h0100, 64'd0);
        i_protected_mode = 1'b0;
        bus.i_req_index = 3'd1;
        bus.i_req_size  = 2'd0;
        bus.i_req_write = 1'b0;
        bus.i_req_fetch = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        saw_stall = 1'b0;
        while (got < 8 && cyc < 200) begin
            @(negedge clock);
            bus.i_req_valid  = (sent < 8);
            bus.i_req_offset = stream_off(sent);
            bus.i_rsp_ready  = !(cyc >= 4 && cyc < 7);
            #1;
            if (!bus.o_req_ready) saw_stall = 1'b1;
            if (bus.i_req_valid && bus.o_req_ready) begin
                exp_q.push_back(32'h1000 + stream_off(sent));
                sent++;
            end
            if (bus.o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_spurious", 64'(bus.o_rsp_linear_address), 64'hDEAD);
                end else begin
                    e = exp_q[0];
                    check_eq("stream_lin", 64'(bus.o_rsp_linear_address), 64'(e));
                    if (bus.i_rsp_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            cyc++;
        end
        @(negedge clock);
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        #1;
        check_eq("stream_got", 64'(got), 64'd8);
        check_eq("stream_left", 64'(exp_q.size()), 64'd0);
        check_eq("stream_stall", 64'(saw_stall), 64'd1);
        check_eq("stream_drain", 64'(bus.o_rsp_valid), 64'd0);

        // Async reset in the middle of traffic
        bus.i_req_valid  = 1'b1;
        bus.i_req_offset = 32'h4;
        cyc = 0;
        while (!bus.o_rsp_valid && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("mid_rsp_seen", 64'(bus.o_rsp_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.o_rsp_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(bus.o_req_ready), 64'd1);
        check_eq("mid_rst_lin", 64'(bus.o_rsp_linear_address), 64'd0);
        bus.i_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        // Shadow was cleared, selector 0 -> linear equals offset
        do_req("post_rst", 1'b0, 2'd0, 3'd1, 32'h5, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0000_0005, 3'd0);

`ifdef SEGMENTATION_ACCESSED_WRITEBACK_EN
        load_entry(3'd2, 16'h0013, d_rw3);
        pulse_cnt = 0;
        do_req("wb1", 1'b1, 2'd3, 3'd2, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0010_0010, 3'd0);
        repeat (3) @(negedge clock);
        check_eq("wb1_pulses", 64'(pulse_cnt), 64'd1);
        check_eq("wb1_idx", 64'(last_pulse_idx), 64'd2);
        do_req("wb2", 1'b1, 2'd3, 3'd2, 32'h10, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0010_0010, 3'd0);
        repeat (3) @(negedge clock);
        check_eq("wb2_pulses", 64'(pulse_cnt), 64'd1);
`endif

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
